// File: rtl/ib_queue.sv
// Dual-issue instruction buffer between IF and ID: circular queue of {pc,inst} that
// presents the two oldest entries to ID and trims wrong-path entries after taken branches.
module ib_queue #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PTR_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             stall_id,
   input  logic [1:0]       if_valid,
   input  logic [31:0]      if_pc0,
   input  logic [31:0]      if_inst0,
   input  logic [31:0]      if_pc1,
   input  logic [31:0]      if_inst1,
   input  logic             launched,
   input  logic             launch_mode,
   input  logic             br_taken,
   output logic [129:0]     ib_to_id_bus,
   output logic             ib_full,
   output logic [PTR_W:0]   ib_count
);

   localparam int unsigned CntW = PTR_W + 1;
   localparam logic [CntW-1:0] FullLvl = CntW'(DEPTH - 2);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             ds_pending_q, ds_pending_d;

   logic [31:0] pc_mem_q   [DEPTH];
   logic [31:0] inst_mem_q [DEPTH];

   logic             full;
   logic             accept;
   logic             pop_req;
   logic [1:0]       pop_want;
   logic [1:0]       pop_n;
   logic [1:0]       push_raw;
   logic [1:0]       push_n;
   logic [CntW-1:0]  remain;
   logic             trim;
   logic             ds_eff;
   logic             we0, we1;
   logic [31:0]      wr0_pc, wr0_inst;
   logic [PTR_W-1:0] head_p1, tail_p1, head_new;

   assign full     = count_q > FullLvl;
   assign accept   = ~full & ~flush;
   assign pop_req  = launched & ~stall_id;
   assign pop_want = pop_req ? (launch_mode ? 2'd2 : 2'd1) : 2'd0;
   assign pop_n    = (CntW'(pop_want) > count_q) ? count_q[1:0] : pop_want;
   assign remain   = count_q - CntW'(pop_n);
   assign trim     = br_taken & pop_req & (pop_n != 2'd0);
   // A lone branch popped from a queue that drains leaves its delay slot still in flight.
   assign ds_eff   = ds_pending_q | (trim & (pop_n == 2'd1) & (remain == '0));

   assign push_raw = {if_valid[0] & if_valid[1], if_valid[0] ^ if_valid[1]};
   assign wr0_pc   = if_valid[0] ? if_pc0 : if_pc1;
   assign wr0_inst = if_valid[0] ? if_inst0 : if_inst1;

   assign head_p1  = head_q + 1'b1;
   assign tail_p1  = tail_q + 1'b1;
   assign head_new = head_q + PTR_W'(pop_n);

   always_comb begin
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      ds_pending_d = ds_pending_q;
      push_n       = 2'd0;
      we0          = 1'b0;
      we1          = 1'b0;
      if (flush) begin
         head_d       = '0;
         tail_d       = '0;
         count_d      = '0;
         ds_pending_d = 1'b0;
      end else begin
         head_d = head_new;
         if (trim && (pop_n == 2'd2)) begin
            tail_d  = head_new;
            count_d = '0;
         end else if (trim && (remain != '0)) begin
            // Only the delay slot survives; everything behind it is wrong path.
            tail_d  = head_new + 1'b1;
            count_d = CntW'(1);
         end else begin
            if (accept) begin
               push_n = (ds_eff && (push_raw != 2'd0)) ? 2'd1 : push_raw;
            end
            we0          = push_n != 2'd0;
            we1          = push_n == 2'd2;
            tail_d       = tail_q + PTR_W'(push_n);
            count_d      = count_q + CntW'(push_n) - CntW'(pop_n);
            ds_pending_d = ds_eff & (push_n == 2'd0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         ds_pending_q <= 1'b0;
      end else begin
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         ds_pending_q <= ds_pending_d;
      end
   end

   // Payload storage needs no reset: unoccupied entries are masked at the output.
   always_ff @(posedge clk) begin
      if (we0) begin
         pc_mem_q[tail_q]   <= wr0_pc;
         inst_mem_q[tail_q] <= wr0_inst;
      end
      if (we1) begin
         pc_mem_q[tail_p1]   <= if_pc1;
         inst_mem_q[tail_p1] <= if_inst1;
      end
   end

   logic        v1, v2;
   logic [31:0] pc1, inst1, pc2, inst2;

   always_comb begin
      v1    = count_q != '0;
      v2    = count_q > CntW'(1);
      pc1   = v1 ? pc_mem_q[head_q]    : 32'd0;
      inst1 = v1 ? inst_mem_q[head_q]  : 32'd0;
      pc2   = v2 ? pc_mem_q[head_p1]   : 32'd0;
      inst2 = v2 ? inst_mem_q[head_p1] : 32'd0;
   end

   assign ib_to_id_bus = {v2, pc2, inst2, v1, pc1, inst1};
   assign ib_full      = full;
   assign ib_count     = count_q;

endmodule

// File: tb/tb_ib_queue.sv
// Scoreboard bench for ib_queue: a queue-based reference model predicts outputs per cycle;
// a monitor compares them against the DUT after each rising edge.
module tb_ib_queue;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned PTR_W = 4;
   localparam int unsigned CW    = PTR_W + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush, stall_id, launched, launch_mode, br_taken;
   logic [1:0]    if_valid;
   logic [31:0]   if_pc0, if_inst0, if_pc1, if_inst1;
   logic [129:0]  ib_to_id_bus;
   logic          ib_full;
   logic [PTR_W:0] ib_count;

   ib_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .stall_id     (stall_id),
      .if_valid     (if_valid),
      .if_pc0       (if_pc0),
      .if_inst0     (if_inst0),
      .if_pc1       (if_pc1),
      .if_inst1     (if_inst1),
      .launched     (launched),
      .launch_mode  (launch_mode),
      .br_taken     (br_taken),
      .ib_to_id_bus (ib_to_id_bus),
      .ib_full      (ib_full),
      .ib_count     (ib_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   typedef struct packed {
      logic [129:0]  bus;
      logic          full;
      logic [CW-1:0] cnt;
   } exp_t;

   ent_t mq[$];
   bit   mds;
   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [129:0] act, input logic [129:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      ent_t e1, e2;
      e1 = (mq.size() >= 1) ? mq[0] : '0;
      e2 = (mq.size() >= 2) ? mq[1] : '0;
      e.bus  = {1'(mq.size() >= 2), e2.pc, e2.inst, 1'(mq.size() >= 1), e1.pc, e1.inst};
      e.full = (int'(DEPTH) - mq.size()) < 2;
      e.cnt  = CW'(mq.size());
      return e;
   endfunction

   // Drive one cycle of stimulus at the falling edge and predict the post-edge outputs.
   task automatic step(input bit fl, input bit st, input logic [1:0] v, input logic [31:0] p0,
                       input logic [31:0] p1, input bit la, input bit md, input bit br);
      logic [31:0] i0, i1;
      ent_t push_l[$];
      ent_t keep;
      int   n, pn;
      bit   full, preq, trim, dse;
      i0 = $urandom;
      i1 = $urandom;
      flush = fl; stall_id = st; if_valid = v;
      if_pc0 = p0; if_inst0 = i0; if_pc1 = p1; if_inst1 = i1;
      launched = la; launch_mode = md; br_taken = br;
      n    = mq.size();
      full = (int'(DEPTH) - n) < 2;
      if (fl) begin
         mq.delete();
         mds = 1'b0;
      end else begin
         if (!full) begin
            if (v[0]) push_l.push_back({p0, i0});
            if (v[1]) push_l.push_back({p1, i1});
         end
         preq = la && !st;
         pn   = preq ? (md ? 2 : 1) : 0;
         if (pn > n) pn = n;
         repeat (pn) void'(mq.pop_front());
         trim = br && preq && (pn > 0);
         if (trim && pn == 2) begin
            mq.delete();
         end else if (trim && mq.size() > 0) begin
            keep = mq[0];
            mq.delete();
            mq.push_back(keep);
         end else begin
            dse = mds || trim;
            if (dse && push_l.size() > 0) begin
               mq.push_back(push_l[0]);
               mds = 1'b0;
            end else begin
               foreach (push_l[k]) mq.push_back(push_l[k]);
               mds = dse;
            end
         end
      end
      exp_q.push_back(model_out());
      @(negedge clk);
   endtask

   task automatic push2(input logic [31:0] pc);
      step(0, 0, 2'b11, pc, pc + 32'd4, 0, 0, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("bus", ib_to_id_bus, e.bus);
            check("full", ib_full, e.full);
            check("count", ib_count, e.cnt);
            check("no_overflow", ib_count <= DEPTH, 1);
         end
      end
   end

   initial begin : stim
      logic [31:0] pc;
      int          phase_la;
      rst = 1'b0; flush = 0; stall_id = 0; if_valid = 0;
      if_pc0 = 0; if_inst0 = 0; if_pc1 = 0; if_inst1 = 0;
      launched = 0; launch_mode = 0; br_taken = 0;
      mds = 1'b0;
      #12;
      check("reset_bus", ib_to_id_bus, 130'd0);
      check("reset_full", ib_full, 0);
      check("reset_count", ib_count, 0);
      @(negedge clk);
      rst = 1'b1;

      push2(32'h100);
      check("dir_first_count", ib_count, 2);
      check("dir_first_pc1", ib_to_id_bus[63:32], 32'h100);
      check("dir_first_pc2", ib_to_id_bus[128:97], 32'h104);
      push2(32'h108);
      step(0, 0, 2'b11, 32'h110, 32'h114, 1, 1, 0);
      check("dir_dual_count", ib_count, 4);
      check("dir_dual_pc1", ib_to_id_bus[63:32], 32'h108);
      step(1, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 7; i++) push2(32'h1000 + 32'(i * 8));
      step(0, 0, 2'b01, 32'h1070, 0, 0, 0, 0);
      check("dir_fill_full", ib_full, 1);
      push2(32'h1080);
      check("dir_full_count", ib_count, 15);
      step(1, 0, 0, 0, 0, 0, 0, 0);

      push2(32'h300);
      push2(32'h308);
      step(0, 0, 2'b11, 32'h310, 32'h314, 1, 0, 1);
      check("dir_trim_count", ib_count, 1);
      check("dir_trim_pc1", ib_to_id_bus[63:32], 32'h304);
      check("dir_trim_v2", ib_to_id_bus[129], 0);
      step(0, 0, 2'b00, 0, 0, 1, 0, 1);
      step(0, 0, 2'b11, 32'h200, 32'h204, 0, 0, 0);
      check("dir_ds_count", ib_count, 1);
      check("dir_ds_pc1", ib_to_id_bus[63:32], 32'h200);

      for (int i = 0; i < 4; i++) push2(32'h400 + 32'(i * 8));
      check("dir_nine", ib_count, 9);
      step(1, 0, 2'b11, 32'h500, 32'h504, 1, 1, 0);
      check("dir_flush_count", ib_count, 0);
      check("dir_flush_bus", ib_to_id_bus, 130'd0);

      push2(32'h600);
      push2(32'h608);
      if_valid = 2'b11; if_pc0 = 32'h700; if_pc1 = 32'h704;
      #2 rst = 1'b0;
      #1;
      check("async_rst_count", ib_count, 0);
      check("async_rst_bus", ib_to_id_bus, 130'd0);
      mq.delete();
      mds = 1'b0;
      @(negedge clk);
      rst = 1'b1; if_valid = 2'b00;

      for (int c = 0; c < 3000; c++) begin
         phase_la = ((c / 150) % 2 == 0) ? 2 : 8;
         pc = $urandom & 32'hffff_fffc;
         step($urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0, 2'($urandom), pc,
              pc + 32'd4, $urandom_range(0, 9) < phase_la, 1'($urandom), $urandom_range(0, 5) == 0);
      end

      step(0, 0, 0, 0, 0, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
